// File: rtl/alu_exec_stage.sv
// Execute stage: ID/EX operand register, A/B operand select, ALU and EX/MEM result register
// with valid/ready flow control. Define ALU_EXEC_OVF_EN to build the registered signed-overflow flag.
module alu_exec_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic             ALUAsrc,
   input  logic [1:0]       ALUBsrc,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   input  logic [15:0]      Imm,
   input  logic [4:0]       Shamt,
   input  logic [4:0]       WriteRegIn,
   input  logic             RegWriteIn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic [WIDTH-1:0] WriteDataOut,
   output logic [4:0]       WriteRegOut,
   output logic             RegWriteOut,
   output logic             Overflow
);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_ADD  = 3'd2,
      OP_SUB  = 3'd3,
      OP_SLL  = 3'd4,
      OP_SRL  = 3'd5,
      OP_SLTU = 3'd6,
      OP_SLT  = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      B_RD2  = 2'd0,
      B_SEXT = 2'd1,
      B_ZEXT = 2'd2,
      B_LUI  = 2'd3
   } b_src_e;

   typedef struct packed {
      logic             a_src;
      b_src_e           b_src;
      alu_op_e          op;
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [15:0]      imm;
      logic [4:0]       shamt;
      logic [4:0]       wreg;
      logic             regwrite;
   } e_entry_t;

   logic             e_valid;
   e_entry_t         e_q;
   logic             adv_m;
   logic             e_load;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_y;

   // M can take a new entry when it is empty or being drained this cycle.
   assign adv_m    = !out_valid || out_ready;
   assign in_ready = (!e_valid || adv_m) && !flush;
   assign e_load   = in_valid && in_ready;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      op_a = e_q.rd1;
      op_b = e_q.rd2;
      if (e_q.a_src) op_a = {{(WIDTH-5){1'b0}}, e_q.shamt};
      case (e_q.b_src)
         B_RD2:  op_b = e_q.rd2;
         B_SEXT: op_b = {{(WIDTH-16){e_q.imm[15]}}, e_q.imm};
         B_ZEXT: op_b = {{(WIDTH-16){1'b0}}, e_q.imm};
         B_LUI:  op_b = WIDTH'({e_q.imm, 16'h0000});
      endcase
   end

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin
      alu_y = '0;
      case (e_q.op)
         OP_AND:  alu_y = op_a & op_b;
         OP_OR:   alu_y = op_a | op_b;
         OP_ADD:  alu_y = sum;
         OP_SUB:  alu_y = diff;
         OP_SLL:  alu_y = op_b << op_a[4:0];
         OP_SRL:  alu_y = op_b >> op_a[4:0];
         OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         e_valid      <= 1'b0;
         out_valid    <= 1'b0;
         ALUResult    <= '0;
         Zero         <= 1'b1;
         WriteDataOut <= '0;
         WriteRegOut  <= '0;
         RegWriteOut  <= 1'b0;
      end else begin
         if (adv_m) begin
            out_valid   <= e_valid;
            RegWriteOut <= e_valid && e_q.regwrite;
            // Data fields keep their last value when a bubble moves into M.
            if (e_valid) begin
               ALUResult    <= alu_y;
               Zero         <= (alu_y == '0);
               WriteDataOut <= e_q.rd2;
               WriteRegOut  <= e_q.wreg;
            end
         end
         if (flush)       e_valid <= 1'b0;
         else if (e_load) e_valid <= 1'b1;
         else if (adv_m)  e_valid <= 1'b0;
      end
   end

   // NOTE: the E payload is not reset; e_valid alone says whether it means anything.
   always_ff @(posedge clk) begin
      if (e_load) begin
         e_q.a_src    <= ALUAsrc;
         e_q.b_src    <= b_src_e'(ALUBsrc);
         e_q.op       <= alu_op_e'(ALUControl);
         e_q.rd1      <= RD1;
         e_q.rd2      <= RD2;
         e_q.imm      <= Imm;
         e_q.shamt    <= Shamt;
         e_q.wreg     <= WriteRegIn;
         e_q.regwrite <= RegWriteIn;
      end
   end

`ifdef ALU_EXEC_OVF_EN
   logic ovf_y;

   // Signed overflow: operand signs versus result sign for ADD and SUB only.
   always_comb begin
      ovf_y = 1'b0;
      if (e_q.op == OP_ADD)
         ovf_y = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      else if (e_q.op == OP_SUB)
         ovf_y = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (reset)                 Overflow <= 1'b0;
      else if (adv_m && e_valid) Overflow <= ovf_y;
   end
`else
   assign Overflow = 1'b0;
`endif

endmodule
